// File: rtl/ustc_crossbar_pipe_if.sv
// Lane-routing bus for ustc_crossbar_pipe: upstream beat with select/mask fields,
// downstream routed beat, each with its own valid/ready handshake.
interface ustc_crossbar_pipe_if #(
  parameter int N_IN    = 8,
  parameter int N_OUT   = 8,
  parameter int DW_DATA = 8,
  parameter int SEL_W   = $clog2(N_IN)
);
  logic                     in_valid;
  logic                     in_ready;
  logic [N_IN*DW_DATA-1:0]  in_data;
  logic [N_OUT*SEL_W-1:0]   in_sel;
  logic [N_OUT-1:0]         in_mask;
  logic                     out_valid;
  logic                     out_ready;
  logic [N_OUT*DW_DATA-1:0] out_data;
  logic [N_OUT-1:0]         out_mask;

  // Environment side: supplies upstream beats and downstream backpressure.
  modport master (
    output in_valid, in_data, in_sel, in_mask, out_ready,
    input  in_ready, out_valid, out_data, out_mask
  );

  // Crossbar side.
  modport slave (
    input  in_valid, in_data, in_sel, in_mask, out_ready,
    output in_ready, out_valid, out_data, out_mask
  );
endinterface

// File: rtl/ustc_crossbar_pipe.sv
// Pipelined N_IN x N_OUT lane crossbar with per-output select/enable, multicast,
// full valid/ready backpressure, delivered-beat counter and sticky illegal-select flag.
module ustc_crossbar_pipe #(
  parameter int N_IN    = 8,
  parameter int N_OUT   = 8,
  parameter int DW_DATA = 8,
  parameter int SEL_W   = $clog2(N_IN),
  parameter int PIPE    = 2,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  ustc_crossbar_pipe_if.slave bus,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic              sel_err
);

  localparam int LW = N_OUT * DW_DATA;

  logic [LW-1:0]    route_data;
  logic [N_OUT-1:0] route_mask;
  logic             route_err;

  logic [PIPE-1:0]  vld;
  logic [PIPE-1:0]  rdy;
  logic [LW-1:0]    data_q [PIPE];
  logic [N_OUT-1:0] mask_q [PIPE];

  logic [PIPE-1:0]  src_vld;
  logic [LW-1:0]    src_data [PIPE];
  logic [N_OUT-1:0] src_mask [PIPE];

  logic             accept;

  // Routing of the presented beat; only captured when it is accepted.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    route_data = '0;
    route_mask = '0;
    route_err  = 1'b0;
    for (int j = 0; j < N_OUT; j++) begin
      if (bus.in_mask[j]) begin
        if ({1'b0, bus.in_sel[j*SEL_W +: SEL_W]} >= (SEL_W+1)'(N_IN)) begin
          route_err = 1'b1;
        end else begin
          route_mask[j] = 1'b1;
          for (int i = 0; i < N_IN; i++) begin
            if (bus.in_sel[j*SEL_W +: SEL_W] == SEL_W'(i)) begin
              route_data[j*DW_DATA +: DW_DATA] = bus.in_data[i*DW_DATA +: DW_DATA];
            end
          end
        end
      end
    end
  end

  // A stage can load when it is empty or its content moves on this cycle;
  // readiness ripples back from the output so a full pipe still streams.
  always_comb begin
    rdy = '0;
    rdy[PIPE-1] = ~vld[PIPE-1] | bus.out_ready;
    for (int k = PIPE - 2; k >= 0; k--) begin
      rdy[k] = ~vld[k] | rdy[k+1];
    end
  end

  always_comb begin
    src_vld     = '0;
    src_vld[0]  = bus.in_valid;
    src_data[0] = route_data;
    src_mask[0] = route_mask;
    for (int k = 1; k < PIPE; k++) begin
      src_vld[k]  = vld[k-1];
      src_data[k] = data_q[k-1];
      src_mask[k] = mask_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the datapath registers are reset too, because the routed lanes and mask are visible on the output and must read zero out of reset.
      vld <= '0;
      for (int k = 0; k < PIPE; k++) begin
        data_q[k] <= '0;
        mask_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < PIPE; k++) begin
        if (rdy[k]) begin
          // NOTE: non-blocking assignments so every stage samples its upstream's pre-edge value.
          vld[k] <= src_vld[k];
          // Payload only moves with a real beat, so an emptied output keeps its last lanes.
          if (src_vld[k]) begin
            data_q[k] <= src_data[k];
            mask_q[k] <= src_mask[k];
          end
        end
      end
    end
  end

  assign accept = bus.in_valid & rdy[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt <= '0;
      sel_err  <= 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready) beat_cnt <= beat_cnt + CNT_W'(1);
      if (accept && route_err)            sel_err  <= 1'b1;
    end
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = vld[PIPE-1];
  assign bus.out_data  = data_q[PIPE-1];
  assign bus.out_mask  = mask_q[PIPE-1];

endmodule

// File: doc/ustc_crossbar_pipe.md
Name: ustc_crossbar_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle one-hot crossbar.
- Routes N_IN input lanes to N_OUT output lanes using a binary per-output select and a per-output enable mask.
- Multicast is allowed: several outputs may take the same input.
- Sits between the operand buffer and the sparse PE array. Carries a valid/ready handshake with full backpressure, zero-fills disabled lanes, counts delivered beats and flags illegal selects.

Parameters:
- N_IN, 8, number of input lanes (2..32).
- N_OUT, 8, number of output lanes (1..32).
- DW_DATA, 8, bits per lane.
- SEL_W, $clog2(N_IN), select field width per output.
- PIPE, 2, register stages input-to-output (1..4).
- CNT_W, 16, beat counter width.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- reset, input, 1, asynchronous active-low reset (0 = reset asserted).
- in_valid, input, 1, upstream beat present.
- in_ready, output, 1, block accepts beat this cycle.
- in_data, input, N_IN*DW_DATA, lane i at bits [i*DW_DATA +: DW_DATA].
- in_sel, input, N_OUT*SEL_W, output j takes input lane in_sel[j*SEL_W +: SEL_W].
- in_mask, input, N_OUT, 1 = output j enabled; 0 = output j driven zero.
- out_valid, output, 1, routed beat present.
- out_ready, input, 1, downstream accepts.
- out_data, output, N_OUT*DW_DATA, routed lanes.
- out_mask, output, N_OUT, effective mask travelling with the beat.
- beat_cnt, output, CNT_W, number of output handshakes completed.
- sel_err, output, 1, sticky: an accepted beat had an enabled select >= N_IN.

Behaviour:
- Reset (reset=0, asynchronous):
  - All stage valid bits, out_data, out_mask, beat_cnt and sel_err clear to 0 immediately.
  - Beats in flight are dropped.
  - in_ready reads 1 once reset is released.
- Accept: a beat is taken on a cycle with in_valid & in_ready.
  - The routing decision (mux on in_sel/in_mask) is computed on the accepted beat before stage 0 registers.
  - Stages 1..PIPE-1 are pure pipeline registers carrying data+mask.
- Routing per output j:
  - if in_mask[j]=0 → lane j = 0, out_mask[j]=0.
  - if in_mask[j]=1 and sel >= N_IN → lane j = 0, out_mask[j]=0, and sel_err sets at accept.
  - otherwise lane j = in_data[sel], out_mask[j]=1.
  - sel_err is cleared only by reset.
- Handshake and pipeline advance:
  - Stage k advances when its downstream is empty or advancing. The last stage's downstream advances when out_ready=1.
  - in_ready = ~valid[0] | advance[0]. It is combinational on pipeline state and out_ready only, never on in_valid.
  - The pipeline holds PIPE beats with no bubbles.
  - Back-to-back accept is sustained at one beat per cycle while out_ready=1.
- Latency: with no backpressure, a beat accepted at cycle t appears with out_valid=1 at cycle t+PIPE.
- Stall:
  - While out_valid & ~out_ready, out_data/out_mask stay stable and out_valid stays 1.
  - Once all stages are full, in_ready=0.
- Ordering: beats leave in acceptance order. There is no drop and no duplication.
- Simultaneous accept and release when full: if out_ready=1 while all stages are full, in_ready=1 that same cycle and throughput is preserved.
- beat_cnt:
  - Increments by 1 on each out_valid & out_ready.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
- Empty pipeline: out_valid=0 and out_data holds its last value. Consumers must not use out_data when out_valid=0.
- Multicast: any number of enabled outputs may select the same input; there is no conflict.
- Inputs are not sampled when in_ready=0.

Test Plan:
- Identity: N_IN=N_OUT=8, PIPE=2, in_data={7,6,5,4,3,2,1,0}, in_sel[j]=j, in_mask=8'hFF, out_ready=1 → out_data={7..0}, out_mask=FF, out_valid rises 2 cycles after accept, beat_cnt=1.
- Reverse + multicast + mask: in_sel={0,0,0,0,7,6,5,4}, in_mask=8'h3F → lanes 0..3 = 4,5,6,7; lanes 4,5 = 0,0; lanes 6,7 = 0 (disabled); out_mask=3F.
- Backpressure: stream 6 beats of value k (k=1..6) with out_ready held 0 for cycles 3..8 → in_ready falls after 2 accepts. out_data stays at beat 1 while stalled. Releasing delivers 1..6 in order, no loss. beat_cnt=6.
- Illegal select: N_IN=6, SEL_W=3, lane 2 sel=7, mask bit 2 set → lane 2=0, out_mask[2]=0, sel_err=1 and stays 1 after further legal beats.
- Reset mid-operation: 2 beats in flight, pull reset=0 asynchronously between edges → out_valid=0, beat_cnt=0, sel_err=0 immediately. After release, in_ready=1 and the next beat returns with latency PIPE.
- Counter wrap: CNT_W=4, deliver 17 beats → beat_cnt=1.
